// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: FSM encodings, default widths and a
// constant-foldable ceil(log2) helper usable in parameter defaults.
package neuron_pkg;

    localparam int DEF_IN_W  = 17;
    localparam int DEF_OUT_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_narrow.sv
// Narrows a signed ACC_W value to OUT_W bits, either clamping or wrapping, and flags
// any change of value. Purely combinational.
module sat_narrow #(
    parameter int ACC_W    = 20,
    parameter int OUT_W    = 18,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] x,
    output logic [OUT_W-1:0] y,
    output logic             ovf
);

    localparam int HI_W = ACC_W - OUT_W + 1;

    // The value fits exactly when every bit from the result sign bit upward agrees.
    logic [HI_W-1:0] hi;
    logic            fits;

    assign hi   = x[ACC_W-1:OUT_W-1];
    assign fits = (hi == '0) || (hi == '1);
    assign ovf  = !fits;

    always_comb begin
        y = x[OUT_W-1:0];
        if ((SATURATE != 0) && !fits) begin
            y = x[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Bias-initialised signed accumulator of N_TERMS streamed terms with a narrowed,
// saturated-or-wrapped result handed off over valid/ready.
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int N_TERMS  = 4,
    parameter int ACC_W    = IN_W + clog2(N_TERMS + 1),
    parameter int OUT_W    = DEF_OUT_W,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int               CNT_W = clog2(N_TERMS) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_sum, bias_ext, term_ext;
    logic [CNT_W-1:0]        cnt;
    logic [OUT_W-1:0]        nar_data;
    logic                    nar_ovf;
    logic                    beat, last_beat, out_hs, reload;

    assign bias_ext  = $signed({{(ACC_W-IN_W){bias[IN_W-1]}}, bias});
    assign term_ext  = $signed({{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data});
    assign acc_sum   = acc + term_ext;
    assign beat      = (state == ACC) && in_valid;
    assign last_beat = beat && (cnt == LAST);
    assign out_hs    = (state == DONE) && out_ready;
    // A start coinciding with the result handshake chains the next sum with no idle cycle.
    assign reload    = ((state == IDLE) || out_hs) && start;

    sat_narrow #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_narrow (
        .x   (acc_sum),
        .y   (nar_data),
        .ovf (nar_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_hs) state_nxt = start ? ACC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            if (reload) begin
                acc <= bias_ext;
                cnt <= '0;
            end else if (beat) begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
            if (last_beat) begin
                out_data <= nar_data;
                out_ovf  <= nar_ovf;
            end
        end
    end

endmodule
